// File: rtl/pe_row_scheduler.sv
// Layer sequencer for a 1xVEC_LEN by VEC_LEN x NUM_OUT product PE: streams x/w pairs, accumulates,
// writes one saturated Q1.14 value per neuron. Define RELU_EN to clamp negative outputs to zero.
module pe_row_scheduler #(
  parameter int VEC_LEN = 784,
  parameter int NUM_OUT = 64,
  parameter int DW      = 16,
  parameter int ACC_W   = 32,
  parameter int XA_W    = 10,
  parameter int WA_W    = 16,
  parameter int YA_W    = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            mem_rd,
  output logic [XA_W-1:0] x_addr,
  output logic [WA_W-1:0] w_addr,
  input  logic [DW-1:0]   x_data,
  input  logic [DW-1:0]   w_data,
  output logic            pe_en,
  output logic [DW-1:0]   pe_a,
  output logic [DW-1:0]   pe_b,
  input  logic [DW-1:0]   pe_dot,
  output logic            y_wr,
  output logic [YA_W-1:0] y_addr,
  output logic [DW-1:0]   y_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [XA_W-1:0] I_LAST = XA_W'(VEC_LEN - 1);
  localparam logic [YA_W-1:0] J_LAST = YA_W'(NUM_OUT - 1);

  state_t                   state_q;
  logic [XA_W-1:0]          i_q;
  logic [YA_W-1:0]          j_q;
  logic [WA_W-1:0]          w_addr_q;
  logic                     drain_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     pe_en_q;
  logic                     pe_en_dly_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     mem_rd_q;
  logic                     y_wr_q;
  logic [YA_W-1:0]          y_addr_q;
  logic [DW-1:0]            y_data_q;
  logic [ACC_W-1:0]         dot_ext_s;
  logic [DW-1:0]            y_next_s;

  function automatic logic [DW-1:0] sat(input logic [ACC_W-1:0] a);
    logic [DW-1:0] r;
    if (a[ACC_W-1:DW-1] == {(ACC_W-DW+1){a[ACC_W-1]}}) begin
      r = a[DW-1:0];
    end else if (a[ACC_W-1]) begin
      r = {1'b1, {(DW-1){1'b0}}};
    end else begin
      r = {1'b0, {(DW-1){1'b1}}};
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] post_act(input logic [DW-1:0] v);
    logic [DW-1:0] r;
`ifdef RELU_EN
    if (v[DW-1]) begin
      r = {DW{1'b0}};
    end else begin
      r = v;
    end
`else
    r = v;
`endif
    return r;
  endfunction

  assign dot_ext_s = {{(ACC_W-DW){pe_dot[DW-1]}}, pe_dot};
  assign y_next_s  = post_act(sat(acc_q));

  // Layer FSM; every output is registered. pe_dot for a read lands two cycles after mem_rd,
  // which is what the two DRAIN cycles cover before WRITE samples the final acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      w_addr_q    <= '0;
      drain_q     <= 1'b0;
      acc_q       <= '0;
      pe_en_q     <= 1'b0;
      pe_en_dly_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      y_wr_q      <= 1'b0;
      y_addr_q    <= '0;
      y_data_q    <= '0;
    end else begin
      y_wr_q      <= 1'b0;
      done_q      <= 1'b0;
      pe_en_q     <= mem_rd_q;
      pe_en_dly_q <= pe_en_q;

      if (state_q == S_WRITE || state_q == S_IDLE) begin
        acc_q <= '0;
      end else if (pe_en_dly_q) begin
        acc_q <= acc_q + $signed(dot_ext_s);
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            mem_rd_q <= 1'b1;
            i_q      <= '0;
            j_q      <= '0;
            w_addr_q <= '0;
          end
        end
        S_RUN: begin
          w_addr_q <= w_addr_q + WA_W'(1);
          if (i_q == I_LAST) begin
            state_q  <= S_DRAIN;
            mem_rd_q <= 1'b0;
            drain_q  <= 1'b0;
          end else begin
            i_q <= i_q + XA_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_q) begin
            state_q <= S_WRITE;
          end else begin
            drain_q <= 1'b1;
          end
        end
        S_WRITE: begin
          y_wr_q   <= 1'b1;
          y_addr_q <= j_q;
          y_data_q <= y_next_s;
          if (j_q == J_LAST) begin
            state_q <= S_FIN;
          end else begin
            j_q      <= j_q + YA_W'(1);
            i_q      <= '0;
            mem_rd_q <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          mem_rd_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign mem_rd = mem_rd_q;
  assign x_addr = i_q;
  assign w_addr = w_addr_q;
  assign pe_en  = pe_en_q;
  assign pe_a   = x_data;
  assign pe_b   = w_data;
  assign y_wr   = y_wr_q;
  assign y_addr = y_addr_q;
  assign y_data = y_data_q;

endmodule

// File: tb/tb_pe_row_scheduler.sv
// Directed bench: a 4x2 instance for the table and corner sequences, a 784x64 instance for random data.
module tb_pe_row_scheduler;

  localparam int SV = 4;
  localparam int SN = 2;
  localparam int BV = 784;
  localparam int BN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_s, busy_s, done_s, mem_rd_s, pe_en_s, y_wr_s;
  logic [1:0]  x_addr_s;
  logic [2:0]  w_addr_s;
  logic [0:0]  y_addr_s;
  logic [15:0] x_data_s, w_data_s, pe_a_s, pe_b_s, pe_dot_s, y_data_s;

  logic        start_b, busy_b, done_b, mem_rd_b, pe_en_b, y_wr_b;
  logic [9:0]  x_addr_b;
  logic [15:0] w_addr_b;
  logic [5:0]  y_addr_b;
  logic [15:0] x_data_b, w_data_b, pe_a_b, pe_b_b, pe_dot_b, y_data_b;

  pe_row_scheduler #(.VEC_LEN(SV), .NUM_OUT(SN), .DW(16), .ACC_W(32), .XA_W(2), .WA_W(3), .YA_W(1)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s), .mem_rd(mem_rd_s),
    .x_addr(x_addr_s), .w_addr(w_addr_s), .x_data(x_data_s), .w_data(w_data_s), .pe_en(pe_en_s),
    .pe_a(pe_a_s), .pe_b(pe_b_s), .pe_dot(pe_dot_s), .y_wr(y_wr_s), .y_addr(y_addr_s), .y_data(y_data_s)
  );

  pe_row_scheduler u_big (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .mem_rd(mem_rd_b),
    .x_addr(x_addr_b), .w_addr(w_addr_b), .x_data(x_data_b), .w_data(w_data_b), .pe_en(pe_en_b),
    .pe_a(pe_a_b), .pe_b(pe_b_b), .pe_dot(pe_dot_b), .y_wr(y_wr_b), .y_addr(y_addr_b), .y_data(y_data_b)
  );

  function automatic logic [15:0] pe_f(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {{16{a[15]}}, a} * {{16{b[15]}}, b};
    return p[29:14];
  endfunction

  function automatic logic [15:0] sat_f(input int s);
    logic [31:0] t;
    t = s;
    if (s > 32767) return 16'h7FFF;
    else if (s < -32768) return 16'h8000;
    else return t[15:0];
  endfunction

  function automatic logic [15:0] act_f(input logic [15:0] v);
`ifdef RELU_EN
    if (v[15]) return 16'h0000;
`endif
    return v;
  endfunction

  logic [15:0] xmem_s [SV];
  logic [15:0] wmem_s [SV*SN];
  logic [15:0] xmem_b [BV];
  logic [15:0] wmem_b [BV*BN];

  // Synchronous layer memories and registered PE for both instances
  always @(posedge clk) begin
    if (mem_rd_s) begin
      x_data_s <= xmem_s[x_addr_s];
      w_data_s <= wmem_s[w_addr_s];
    end
    if (pe_en_s) pe_dot_s <= pe_f(pe_a_s, pe_b_s);
    if (mem_rd_b) begin
      x_data_b <= xmem_b[x_addr_b];
      w_data_b <= wmem_b[w_addr_b];
    end
    if (pe_en_b) pe_dot_b <= pe_f(pe_a_b, pe_b_b);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  int          done_cyc;
  int          ylog_a[$];
  logic [15:0] ylog_d[$];
  int          xlog[$];
  int          wlog[$];

  task automatic set_start(input bit big, input logic v);
    if (big) start_b = v;
    else start_s = v;
  endtask

  // One pass; cycle 0 is the cycle after the start edge, sampled at falling edges
  task automatic run_pass(input bit big, input bit hold, input int limit);
    done_cyc = -1;
    ylog_a.delete(); ylog_d.delete(); xlog.delete(); wlog.delete();
    @(negedge clk); set_start(big, 1'b1);
    @(negedge clk); set_start(big, hold);
    chk("busy_cycle0", big ? busy_b : busy_s, 32'd1);
    for (int c = 0; c < limit; c++) begin
      if (!big && mem_rd_s) begin
        xlog.push_back(int'(x_addr_s));
        wlog.push_back(int'(w_addr_s));
      end
      if (big ? y_wr_b : y_wr_s) begin
        ylog_a.push_back(big ? int'(y_addr_b) : int'(y_addr_s));
        ylog_d.push_back(big ? y_data_b : y_data_s);
      end
      if (big ? done_b : done_s) begin
        done_cyc = c;
        chk("busy_at_done", big ? busy_b : busy_s, 32'd0);
        break;
      end
      @(negedge clk);
    end
    set_start(big, 1'b0);
    if (done_cyc < 0) $display("FAIL done_timeout actual=none required=done within %0d cycles", limit);
  endtask

  task automatic fill_small(input logic [15:0] xv, input logic [15:0] wv);
    for (int i = 0; i < SV; i++) xmem_s[i] = xv;
    for (int k = 0; k < SV*SN; k++) wmem_s[k] = wv;
  endtask

  task automatic check_small_pass(input string nm, input logic [15:0] ye);
    chk({nm, "_done_cyc"}, done_cyc, 32'd15);
    chk({nm, "_nwr"}, ylog_d.size(), 32'd2);
    for (int j = 0; j < SN && j < ylog_d.size(); j++) begin
      chk({nm, "_yaddr"}, ylog_a[j], j);
      chk({nm, "_ydata"}, ylog_d[j], act_f(ye));
    end
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] w;
    logic [15:0] y;
  } vec_t;

  vec_t vt[8];
  int   nw;
  int   acc;

  initial begin
    vt[0] = '{16'h2000, 16'h2000, 16'h4000};
    vt[1] = '{16'h4000, 16'h4000, 16'h7FFF};
    vt[2] = '{16'h4000, 16'hC000, 16'h8000};
    vt[3] = '{16'h2000, 16'hE000, 16'hC000};
    vt[4] = '{16'h4000, 16'h2000, 16'h7FFF};
    vt[5] = '{16'h4000, 16'hE000, 16'h8000};
    vt[6] = '{16'h7FFF, 16'h0001, 16'h0004};
    vt[7] = '{16'h8000, 16'h0001, 16'hFFF8};

    rst = 1'b1; start_s = 1'b0; start_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_s, 32'd0);
    chk("rst_done", done_s, 32'd0);
    chk("rst_mem_rd", mem_rd_s, 32'd0);
    chk("rst_pe_en", pe_en_s, 32'd0);
    chk("rst_y_wr", y_wr_s, 32'd0);
    chk("rst_addrs", {x_addr_s, w_addr_s, y_addr_s}, 32'd0);
    chk("rst_y_data", y_data_s, 32'd0);
    chk("rst_big_busy", busy_b, 32'd0);
    rst = 1'b0;

    for (int r = 0; r < 8; r++) begin
      fill_small(vt[r].x, vt[r].w);
      run_pass(1'b0, 1'b0, 40);
      check_small_pass($sformatf("vec%0d", r), vt[r].y);
    end

    // Addressing: w[j][i] = j*4+i with x = 1.0 gives y0 = 6, y1 = 22
    for (int i = 0; i < SV; i++) xmem_s[i] = 16'h4000;
    for (int k = 0; k < SV*SN; k++) wmem_s[k] = 16'(k);
    run_pass(1'b0, 1'b0, 40);
    chk("addr_nreads", xlog.size(), 32'd8);
    for (int k = 0; k < 8 && k < xlog.size(); k++) begin
      chk("addr_x", xlog[k], k % 4);
      chk("addr_w", wlog[k], k);
    end
    chk("addr_nwr", ylog_d.size(), 32'd2);
    if (ylog_d.size() == 2) begin
      chk("addr_y0", {16'(ylog_a[0]), ylog_d[0]}, {16'd0, 16'd6});
      chk("addr_y1", {16'(ylog_a[1]), ylog_d[1]}, {16'd1, 16'd22});
    end

    // Start held through the pass: one pass, one done, nothing afterwards
    fill_small(16'h2000, 16'h2000);
    run_pass(1'b0, 1'b1, 40);
    check_small_pass("held", 16'h4000);
    nw = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (y_wr_s || done_s || mem_rd_s) nw++;
    end
    chk("held_no_second_pass", nw, 32'd0);

    // Reset asserted in cycle 5 of a pass
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {busy_s, done_s, mem_rd_s, pe_en_s, y_wr_s}, 32'd0);
    chk("midrst_addrs", {x_addr_s, w_addr_s, y_addr_s}, 32'd0);
    chk("midrst_y_data", y_data_s, 32'd0);
    @(negedge clk); rst = 1'b0;
    nw = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (y_wr_s || busy_s || mem_rd_s) nw++;
    end
    chk("midrst_quiet", nw, 32'd0);
    run_pass(1'b0, 1'b0, 40);
    check_small_pass("after_rst", 16'h4000);

    // Full-size layer with random data; first half of the neurons use small weights
    for (int i = 0; i < BV; i++) xmem_b[i] = 16'($urandom_range(0, 65534) - 32767);
    for (int k = 0; k < BV*BN; k++) begin
      if (k < BV*BN/2) wmem_b[k] = 16'($urandom_range(0, 4094) - 2047);
      else wmem_b[k] = 16'($urandom_range(0, 65534) - 32767);
    end
    run_pass(1'b1, 1'b0, BN*(BV+3) + 20);
    chk("big_done_cyc", done_cyc, BN*(BV+3) + 1);
    chk("big_nwr", ylog_d.size(), BN);
    for (int j = 0; j < BN && j < ylog_d.size(); j++) begin
      acc = 0;
      for (int i = 0; i < BV; i++) acc += int'($signed(pe_f(xmem_b[i], wmem_b[j*BV+i])));
      chk($sformatf("big_y%0d_addr", j), ylog_a[j], j);
      chk($sformatf("big_y%0d_data", j), ylog_d[j], act_f(sat_f(acc)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
